isqrt_arbiter: RTL and testbench

ISQRT_ARBITER -- requirements
Module: isqrt_arbiter

---
 rtl/isqrt_arbiter.sv | 96 +++++++++
 tb/tb_isqrt_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_arbiter.sv
// Shares one in-order, pipelined isqrt unit between two requesters. A 1-bit tag
// FIFO records who issued each operand so that results can be routed back.
module isqrt_arbiter #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_vld,
  input  logic [31:0] req0_x,
  input  logic        req1_vld,
  input  logic [31:0] req1_x,
  output logic        req0_rdy,
  output logic        req1_rdy,
  output logic        rsp0_vld,
  output logic [15:0] rsp0_y,
  output logic        rsp1_vld,
  output logic [15:0] rsp1_y,
  output logic        isqrt_x_vld,
  output logic [31:0] isqrt_x,
  input  logic        isqrt_y_vld,
  input  logic [15:0] isqrt_y,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          prio_q, prio_d;
  logic          err_q, err_d;
  logic          tag_mem_q [DEPTH];

  logic full, empty, gnt0, gnt1, push, pop, head_tag;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // prio_q = 0 favours req0 when both requesters are valid
  assign gnt0 = !full && req0_vld && (!req1_vld || !prio_q);
  assign gnt1 = !full && req1_vld && (!req0_vld || prio_q);
  assign push = gnt0 | gnt1;
  assign pop  = isqrt_y_vld && !empty;
  assign head_tag = tag_mem_q[rd_ptr_q];

  assign req0_rdy    = gnt0;
  assign req1_rdy    = gnt1;
  assign isqrt_x_vld = push;
  assign isqrt_x     = gnt1 ? req1_x : (gnt0 ? req0_x : '0);

  assign rsp0_vld = pop && !head_tag;
  assign rsp1_vld = pop && head_tag;
  assign rsp0_y   = rsp0_vld ? isqrt_y : '0;
  assign rsp1_y   = rsp1_vld ? isqrt_y : '0;

  assign busy = !empty;
  assign err  = err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
    prio_d = push ? gnt0 : prio_q;
    err_d  = err_q | (isqrt_y_vld && empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      prio_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      prio_q   <= prio_d;
      err_q    <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q says they are live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= gnt1;
    end
  end

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Directed bench for isqrt_arbiter: a vector table for single-cycle behaviour, then
// hand-written sequences (reset, spurious result, full FIFO, pointer wrap) with an isqrt model.
module tb_isqrt_arbiter;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_vld, req1_vld;
  logic [31:0] req0_x, req1_x;
  logic        req0_rdy, req1_rdy;
  logic        rsp0_vld, rsp1_vld;
  logic [15:0] rsp0_y, rsp1_y;
  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld;
  logic [15:0] isqrt_y;
  logic        busy, err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  isqrt_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_x(req0_x),
    .req1_vld(req1_vld), .req1_x(req1_x),
    .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
    .rsp0_vld(rsp0_vld), .rsp0_y(rsp0_y),
    .rsp1_vld(rsp1_vld), .rsp1_y(rsp1_y),
    .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y),
    .busy(busy), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= longint'(x)) r++;
    return 16'(r);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic v0; logic [31:0] x0; logic v1; logic [31:0] x1; logic yv; logic [15:0] y;
    logic e_r0; logic e_r1; logic e_xv; logic [31:0] e_x;
    logic e_s0v; logic [15:0] e_s0y; logic e_s1v; logic [15:0] e_s1y;
    logic e_busy; logic e_err;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  function automatic vec_t mk(input int v0, input int x0, input int v1, input int x1,
                              input int yv, input int y, input int r0, input int r1,
                              input int xv, input int x, input int s0v, input int s0y,
                              input int s1v, input int s1y, input int b, input int e);
    vec_t t;
    t.v0 = 1'(v0);     t.x0 = 32'(x0);    t.v1 = 1'(v1);    t.x1 = 32'(x1);
    t.yv = 1'(yv);     t.y = 16'(y);
    t.e_r0 = 1'(r0);   t.e_r1 = 1'(r1);   t.e_xv = 1'(xv);  t.e_x = 32'(x);
    t.e_s0v = 1'(s0v); t.e_s0y = 16'(s0y);
    t.e_s1v = 1'(s1v); t.e_s1y = 16'(s1y);
    t.e_busy = 1'(b);  t.e_err = 1'(e);
    return t;
  endfunction

  // ---------------- model state for the sequences ----------------
  typedef struct { int due; logic [15:0] y; } pend_t;
  pend_t       pq[$];
  bit          m_tags[$];
  logic [15:0] sb0[$], sb1[$];
  bit          m_prio = 1'b0;
  bit          m_err  = 1'b0;
  int          cyc = 0;
  int          lat = 4;
  bit          spur = 1'b0;
  logic [15:0] spur_y = 16'd0;
  bit          model_y;
  logic        act_rdy0;

  task automatic step(input string tag, input logic v0, input logic [31:0] x0,
                      input logic v1, input logic [31:0] x1);
    logic g0, g1, full;
    logic e_s0v, e_s1v;
    logic [15:0] e_s0y, e_s1y;
    logic [31:0] e_x;
    bit t;
    int cnt;
    req0_vld = v0; req0_x = x0; req1_vld = v1; req1_x = x1;
    isqrt_y_vld = 1'b0; isqrt_y = 16'd0; model_y = 1'b0;
    if (spur) begin
      isqrt_y_vld = 1'b1; isqrt_y = spur_y;
    end else if (pq.size() > 0 && pq[0].due == cyc) begin
      isqrt_y_vld = 1'b1; isqrt_y = pq[0].y; model_y = 1'b1;
    end
    #2;
    cnt  = m_tags.size();
    full = (cnt == DEPTH);
    g0 = 1'b0; g1 = 1'b0;
    if (!full) begin
      if (v0 && v1) begin
        g0 = !m_prio; g1 = m_prio;
      end else begin
        g0 = v0; g1 = v1;
      end
    end
    e_x = g0 ? x0 : (g1 ? x1 : 32'd0);
    e_s0v = 1'b0; e_s1v = 1'b0; e_s0y = 16'd0; e_s1y = 16'd0;
    if (isqrt_y_vld && cnt != 0) begin
      t = m_tags.pop_front();
      if (!t) begin e_s0v = 1'b1; e_s0y = sb0.pop_front(); end
      else    begin e_s1v = 1'b1; e_s1y = sb1.pop_front(); end
    end
    act_rdy0 = req0_rdy;
    chk({tag, " rdy0"}, 32'(req0_rdy), 32'(g0));
    chk({tag, " rdy1"}, 32'(req1_rdy), 32'(g1));
    chk({tag, " xvld"}, 32'(isqrt_x_vld), 32'(g0 | g1));
    chk({tag, " x"}, isqrt_x, e_x);
    chk({tag, " rsp0v"}, 32'(rsp0_vld), 32'(e_s0v));
    chk({tag, " rsp0y"}, 32'(rsp0_y), 32'(e_s0y));
    chk({tag, " rsp1v"}, 32'(rsp1_vld), 32'(e_s1v));
    chk({tag, " rsp1y"}, 32'(rsp1_y), 32'(e_s1y));
    chk({tag, " busy"}, 32'(busy), 32'(cnt != 0));
    chk({tag, " err"}, 32'(err), 32'(m_err));
    if (isqrt_y_vld && cnt == 0) m_err = 1'b1;
    if (model_y) void'(pq.pop_front());
    if (g0 || g1) begin
      m_tags.push_back(g1);
      pq.push_back('{cyc + lat, isqrt_ref(e_x)});
      if (g1) sb1.push_back(isqrt_ref(e_x));
      else    sb0.push_back(isqrt_ref(e_x));
      m_prio = !g1;
    end
    $display("[%0d] %s v=%0d%0d rdy=%0d%0d yv=%0d rsp=%0d%0d", cyc, tag, v0, v1,
             req0_rdy, req1_rdy, isqrt_y_vld, rsp0_vld, rsp1_vld);
    @(negedge clk);
    cyc++;
    chk({tag, " count"}, 32'(dut.count_q), 32'(m_tags.size()));
  endtask

  task automatic model_clear();
    pq.delete(); m_tags.delete(); sb0.delete(); sb1.delete();
    m_prio = 1'b0; m_err = 1'b0;
  endtask

  // Reset asserted between clock edges; checks the immediate effect, releases on next negedge.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
    chk({tag, " prio"}, 32'(dut.prio_q), 32'd0);
    model_clear();
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    int ngrant;
    bit seen_y;
    rst_n = 1'b0;
    req0_vld = 1'b0; req0_x = '0; req1_vld = 1'b0; req1_x = '0;
    isqrt_y_vld = 1'b0; isqrt_y = '0;

    //           v0  x0  v1 x1  yv  y  | r0 r1 xv x    s0v s0y s1v s1y busy err
    tbl[0]  = mk(0,   0, 0,  0, 0,  0,   0, 0, 0,   0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 144, 0,  0, 0,  0,   1, 0, 1, 144, 0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(0,   0, 0,  0, 0,  0,   0, 0, 0,   0, 0,  0, 0, 0, 1, 0);
    tbl[3]  = mk(0,   0, 0,  0, 1, 12,   0, 0, 0,   0, 1, 12, 0, 0, 1, 0);
    tbl[4]  = mk(0,   0, 0,  0, 0,  0,   0, 0, 0,   0, 0,  0, 0, 0, 0, 0);
    tbl[5]  = mk(1,  16, 1, 81, 0,  0,   0, 1, 1,  81, 0,  0, 0, 0, 0, 0);
    tbl[6]  = mk(1,  16, 1, 81, 0,  0,   1, 0, 1,  16, 0,  0, 0, 0, 1, 0);
    tbl[7]  = mk(1,  16, 1, 81, 0,  0,   0, 1, 1,  81, 0,  0, 0, 0, 1, 0);
    tbl[8]  = mk(1,  16, 1, 81, 0,  0,   1, 0, 1,  16, 0,  0, 0, 0, 1, 0);
    tbl[9]  = mk(0,   0, 0,  0, 1,  9,   0, 0, 0,   0, 0,  0, 1, 9, 1, 0);
    tbl[10] = mk(0,   0, 0,  0, 1,  4,   0, 0, 0,   0, 1,  4, 0, 0, 1, 0);
    tbl[11] = mk(0,   0, 0,  0, 1,  9,   0, 0, 0,   0, 0,  0, 1, 9, 1, 0);
    tbl[12] = mk(0,   0, 0,  0, 1,  4,   0, 0, 0,   0, 1,  4, 0, 0, 1, 0);
    tbl[13] = mk(0,   0, 0,  0, 0,  0,   0, 0, 0,   0, 0,  0, 0, 0, 0, 0);
    tbl[14] = mk(1,  25, 0,  0, 0,  0,   1, 0, 1,  25, 0,  0, 0, 0, 0, 0);
    tbl[15] = mk(0,   0, 1, 49, 1,  5,   0, 1, 1,  49, 1,  5, 0, 0, 1, 0);
    tbl[16] = mk(0,   0, 0,  0, 1,  7,   0, 0, 0,   0, 0,  0, 1, 7, 1, 0);
    tbl[17] = mk(0,   0, 0,  0, 0,  0,   0, 0, 0,   0, 0,  0, 0, 0, 0, 0);
    tbl[18] = mk(0,   0, 0,  0, 1,  3,   0, 0, 0,   0, 0,  0, 0, 0, 0, 0);
    tbl[19] = mk(0,   0, 0,  0, 0,  0,   0, 0, 0,   0, 0,  0, 0, 0, 0, 1);
    tbl[20] = mk(1,   4, 0,  0, 0,  0,   1, 0, 1,   4, 0,  0, 0, 0, 0, 1);
    tbl[21] = mk(0,   0, 0,  0, 1,  2,   0, 0, 0,   0, 1,  2, 0, 0, 1, 1);
    tbl[22] = mk(0,   0, 0,  0, 0,  0,   0, 0, 0,   0, 0,  0, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      req0_vld = tbl[i].v0; req0_x = tbl[i].x0;
      req1_vld = tbl[i].v1; req1_x = tbl[i].x1;
      isqrt_y_vld = tbl[i].yv; isqrt_y = tbl[i].y;
      #2;
      chk($sformatf("v%0d rdy0", i), 32'(req0_rdy), 32'(tbl[i].e_r0));
      chk($sformatf("v%0d rdy1", i), 32'(req1_rdy), 32'(tbl[i].e_r1));
      chk($sformatf("v%0d xvld", i), 32'(isqrt_x_vld), 32'(tbl[i].e_xv));
      chk($sformatf("v%0d x", i), isqrt_x, tbl[i].e_x);
      chk($sformatf("v%0d rsp0v", i), 32'(rsp0_vld), 32'(tbl[i].e_s0v));
      chk($sformatf("v%0d rsp0y", i), 32'(rsp0_y), 32'(tbl[i].e_s0y));
      chk($sformatf("v%0d rsp1v", i), 32'(rsp1_vld), 32'(tbl[i].e_s1v));
      chk($sformatf("v%0d rsp1y", i), 32'(rsp1_y), 32'(tbl[i].e_s1y));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("v%0d err", i), 32'(err), 32'(tbl[i].e_err));
      $display("vec %0d: rdy=%0d%0d xvld=%0d x=%0d rsp=%0d%0d busy=%0d err=%0d", i,
               req0_rdy, req1_rdy, isqrt_x_vld, isqrt_x, rsp0_vld, rsp1_vld, busy, err);
      @(negedge clk);
    end

    // Reset with 5 outstanding while err=1 and prio=1
    m_prio = 1'b1; m_err = 1'b1; lat = 20;
    for (int i = 0; i < 4; i++) step("out1", 1'b0, 32'd0, 1'b1, 32'(100 + i));
    step("out0", 1'b1, 32'd196, 1'b0, 32'd0);
    mid_reset("rst5");
    lat = 4;
    step("rst_both", 1'b1, 32'd400, 1'b1, 32'd625);
    repeat (lat + 2) step("drain", 1'b0, 32'd0, 1'b0, 32'd0);

    // Spurious result when idle: dropped, err sticky until reset
    spur = 1'b1; spur_y = 16'd77;
    step("spur", 1'b0, 32'd0, 1'b0, 32'd0);
    spur = 1'b0;
    repeat (4) step("sticky", 1'b0, 32'd0, 1'b0, 32'd0);
    mid_reset("rst_err");

    // Latency longer than DEPTH: grants stop at full, resume the cycle after the first pop
    lat = 12; ngrant = 0; seen_y = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (pq.size() > 0 && pq[0].due == cyc) seen_y = 1'b1;
      step("full", 1'b1, 32'(1000 + c * 37), 1'b0, 32'd0);
      if (!seen_y && act_rdy0) ngrant++;
    end
    chk("full grants", 32'(ngrant), 32'(DEPTH));
    repeat (lat + 2) step("drain", 1'b0, 32'd0, 1'b0, 32'd0);

    // Short latency, steady push+pop across several pointer wraps
    lat = 3;
    for (int i = 0; i < 48; i++) begin
      step("wrap", 1'((i % 5) != 4), 32'(1000 + i * 7), 1'((i % 3) != 2), 32'(50000 + i * 13));
      if (i == 20) chk("wrap count3", 32'(dut.count_q), 32'd3);
    end
    repeat (lat + 2) step("drain", 1'b0, 32'd0, 1'b0, 32'd0);
    chk("end busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
